// File: rtl/cordic_atan.sv
// cordic_atan: multicycle vectoring-mode CORDIC computing atan2(y, x) in
// radians from two float32 operands; the result is a float32 in (-pi, pi].
//
// Optional feature macro: CORDIC_ATAN_NAN_EN
//   defined   : a NaN operand, or both operands infinite, yields 0x7FC00000.
//   undefined : exponent 255 is an ordinary exponent; no NaN is produced.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   start   request, sampled only while idle
//   x, y    float32 abscissa / ordinate, captured on an accepted start
//   result  float32 angle, valid from the done cycle, held until next done
//   done    one-cycle completion pulse
//   busy    high from accepted start through done, inclusive
module cordic_atan #(
    parameter int unsigned ITER = 24,
    parameter int unsigned W    = 28
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
);

    localparam int unsigned CW  = 5;       // iteration counter width (ITER <= 28)
    localparam int unsigned LSH = W - 26;  // places the hidden one 2 bits below the sign
    localparam logic signed [31:0] HALF_PI = 32'sh3243F6A9;  // pi/2 in Q3.29
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALIGN,
        S_ITER,
        S_PACK
    } state_t;

    state_t               state;
    logic [31:0]          xin;
    logic [31:0]          yin;
    logic signed [W-1:0]  xr;
    logic signed [W-1:0]  yr;
    logic signed [31:0]   zr;
    logic [CW-1:0]        cnt;
    logic                 zero_f;
    logic                 nan_f;

    // atan(2^-i) in Q3.29, rounded to nearest
    function automatic logic signed [31:0] atan_lut(input logic [CW-1:0] i);
        logic signed [31:0] v;
        case (i)
            5'd0:    v = 32'sd421657428;
            5'd1:    v = 32'sd248918915;
            5'd2:    v = 32'sd131521918;
            5'd3:    v = 32'sd66762579;
            5'd4:    v = 32'sd33510843;
            5'd5:    v = 32'sd16771758;
            5'd6:    v = 32'sd8387925;
            5'd7:    v = 32'sd4194219;
            5'd8:    v = 32'sd2097141;
            5'd9:    v = 32'sd1048575;
            5'd10:   v = 32'sd524288;
            5'd11:   v = 32'sd262144;
            5'd12:   v = 32'sd131072;
            5'd13:   v = 32'sd65536;
            5'd14:   v = 32'sd32768;
            5'd15:   v = 32'sd16384;
            5'd16:   v = 32'sd8192;
            5'd17:   v = 32'sd4096;
            5'd18:   v = 32'sd2048;
            5'd19:   v = 32'sd1024;
            5'd20:   v = 32'sd512;
            5'd21:   v = 32'sd256;
            5'd22:   v = 32'sd128;
            5'd23:   v = 32'sd64;
            5'd24:   v = 32'sd32;
            5'd25:   v = 32'sd16;
            5'd26:   v = 32'sd8;
            5'd27:   v = 32'sd4;
            default: v = 32'sd0;
        endcase
        return v;
    endfunction

    // Unpack both operands and align them to the larger exponent
    logic [7:0]          ex, ey, emax, dx, dy;
    logic [W-1:0]        mx_w, my_w, ax, ay;
    logic signed [W-1:0] sx, sy;
    logic                nan_c;

    always_comb begin
        ex   = xin[30:23];
        ey   = yin[30:23];
        mx_w = (ex == 8'd0) ? '0 : (W'({1'b1, xin[22:0]}) << LSH);
        my_w = (ey == 8'd0) ? '0 : (W'({1'b1, yin[22:0]}) << LSH);
        emax = (ex > ey) ? ex : ey;
        dx   = emax - ex;
        dy   = emax - ey;
        ax   = (32'(dx) >= W) ? '0 : (mx_w >> dx);
        ay   = (32'(dy) >= W) ? '0 : (my_w >> dy);
        sx   = xin[31] ? -$signed(ax) : $signed(ax);
        sy   = yin[31] ? -$signed(ay) : $signed(ay);
`ifdef CORDIC_ATAN_NAN_EN
        nan_c = ((ex == 8'hFF) && (xin[22:0] != 23'd0)) ||
                ((ey == 8'hFF) && (yin[22:0] != 23'd0)) ||
                ((ex == 8'hFF) && (ey == 8'hFF) &&
                 (xin[22:0] == 23'd0) && (yin[22:0] == 23'd0));
`else
        nan_c = 1'b0;
`endif
    end

    // One micro-rotation: drive y toward zero, accumulating the angle in z
    logic signed [W-1:0] xs, ys, x_n, y_n;
    logic signed [31:0]  z_n;

    always_comb begin
        xs = xr >>> cnt;
        ys = yr >>> cnt;
        if (!yr[W-1]) begin
            x_n = xr + ys;
            y_n = yr - xs;
            z_n = zr + atan_lut(cnt);
        end else begin
            x_n = xr - ys;
            y_n = yr + xs;
            z_n = zr - atan_lut(cnt);
        end
    end

    // Convert Q3.29 z to float32 with a truncated mantissa
    logic [31:0] mag;
    logic [4:0]  p;
    logic [22:0] mant;
    logic [31:0] pack_c;

    always_comb begin
        mag = zr[31] ? 32'(-zr) : 32'(zr);
        p   = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) p = 5'(i);
        end
        mant = 23'((mag << (5'd31 - p)) >> 8);
        if (nan_f)
            pack_c = QNAN;
        else if (zero_f || (mag == 32'd0))
            pack_c = 32'h0000_0000;
        else
            pack_c = {zr[31], 8'(8'd98 + {3'b000, p}), mant};
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            result <= 32'h0000_0000;
            done   <= 1'b0;
            busy   <= 1'b0;
            xin    <= '0;
            yin    <= '0;
            xr     <= '0;
            yr     <= '0;
            zr     <= '0;
            cnt    <= '0;
            zero_f <= 1'b0;
            nan_f  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= start;
                    if (start) begin
                        xin   <= x;
                        yin   <= y;
                        state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    zero_f <= (ex == 8'd0) && (ey == 8'd0);
                    nan_f  <= nan_c;
                    cnt    <= '0;
                    // Pre-rotate left-half-plane vectors into the right half
                    if (sx[W-1] && !sy[W-1]) begin
                        xr <= sy;
                        yr <= -sx;
                        zr <= HALF_PI;
                    end else if (sx[W-1] && sy[W-1]) begin
                        xr <= -sy;
                        yr <= sx;
                        zr <= -HALF_PI;
                    end else begin
                        xr <= sx;
                        yr <= sy;
                        zr <= 32'sd0;
                    end
                    state <= S_ITER;
                end
                S_ITER: begin
                    xr  <= x_n;
                    yr  <= y_n;
                    zr  <= z_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) state <= S_PACK;
                end
                S_PACK: begin
                    result <= pack_c;
                    done   <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_atan.sv
// Scoreboard bench for cordic_atan: the driver pushes expected angles as it
// issues requests; a monitor pops and checks whenever done pulses.
module tb_cordic_atan;

    localparam int LAT = 26;
    localparam int K_TOL    = 0;
    localparam int K_EXACT  = 1;
    localparam int K_NOTNAN = 2;
    localparam real TOL = 9.5367431640625e-07;  // 2^-20

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int n_vec  = 0;
    int n_bad  = 0;
    int n_done = 0;
    int cyc    = 0;

    real         q_val[$];
    int          q_kind[$];
    logic [31:0] q_bits[$];
    int          q_start[$];
    string       q_name[$];

    cordic_atan dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .x      (x),
        .y      (y),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        m = m * (2.0 ** e);
        return b[31] ? -m : m;
    endfunction

    task automatic check_bits(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Scoreboard monitor
    real         m_val;
    int          m_kind;
    logic [31:0] m_bits;
    int          m_start;
    string       m_name;
    real         m_err;

    always @(posedge clk) begin
        #1;
        if (done) begin
            n_done++;
            if (q_kind.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: result %h, expected no done", result);
            end else begin
                m_val   = q_val.pop_front();
                m_kind  = q_kind.pop_front();
                m_bits  = q_bits.pop_front();
                m_start = q_start.pop_front();
                m_name  = q_name.pop_front();
                n_vec++;
                if (m_kind == K_EXACT) begin
                    if (result !== m_bits) begin
                        n_bad++;
                        $display("FAIL %s: got %h, expected %h", m_name, result, m_bits);
                    end
                end else if (m_kind == K_NOTNAN) begin
                    if (result[30:23] == 8'hFF) begin
                        n_bad++;
                        $display("FAIL %s: got %h, expected a non-NaN value", m_name, result);
                    end
                end else begin
                    m_err = f2r(result) - m_val;
                    if (m_err < 0.0) m_err = -m_err;
                    if (m_err > TOL) begin
                        n_bad++;
                        $display("FAIL %s: got %h (%f), expected %f within 2^-20",
                                 m_name, result, f2r(result), m_val);
                    end
                end
                n_vec++;
                if (cyc - m_start != LAT) begin
                    n_bad++;
                    $display("FAIL %s_latency: got %0d cycles, expected %0d",
                             m_name, cyc - m_start, LAT);
                end
            end
        end
    end

    // Issue a request; when push is set, queue its expectation
    task automatic issue(input string name, input logic [31:0] xa, input logic [31:0] ya,
                         input int kind, input real val, input logic [31:0] bits, input bit push);
        @(negedge clk);
        start = 1'b1;
        x     = xa;
        y     = ya;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_busy: got %b, expected 1", name, busy);
        end
        if (push) begin
            q_val.push_back(val);
            q_kind.push_back(kind);
            q_bits.push_back(bits);
            q_start.push_back(cyc);
            q_name.push_back(name);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: got no done in 60 cycles, expected done", name);
        end
    endtask

    int done_before;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        x     = 32'h0;
        y     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_bits("reset_result", result, 32'h0000_0000);
        check_bits("reset_done", 32'(done), 32'h0);
        check_bits("reset_busy", 32'(busy), 32'h0);

        // Directed vectors, each issued the cycle after the previous done
        issue("q1_45deg", 32'h3F800000, 32'h3F800000, K_TOL, 0.7853981633974483, 32'h0, 1'b1);
        wait_done("q1_45deg");
        issue("pi", 32'hBF800000, 32'h00000000, K_TOL, 3.141592653589793, 32'h0, 1'b1);
        wait_done("pi");
        issue("neg_half_pi", 32'h00000000, 32'hBF800000, K_TOL, -1.5707963267948966, 32'h0, 1'b1);
        wait_done("neg_half_pi");
        issue("neg_60deg", 32'h3F000000, 32'hBF5DB3D7, K_TOL, -1.0471975511965976, 32'h0, 1'b1);
        wait_done("neg_60deg");
        issue("zero", 32'h00000000, 32'h00000000, K_EXACT, 0.0, 32'h00000000, 1'b1);
        wait_done("zero");
        issue("q3_m135deg", 32'hBF800000, 32'hBF800000, K_TOL, -2.356194490192345, 32'h0, 1'b1);
        wait_done("q3_m135deg");
`ifdef CORDIC_ATAN_NAN_EN
        issue("nan_x", 32'h7FC00000, 32'h3F800000, K_EXACT, 0.0, 32'h7FC00000, 1'b1);
        wait_done("nan_x");
        issue("inf_inf", 32'h7F800000, 32'h7F800000, K_EXACT, 0.0, 32'h7FC00000, 1'b1);
        wait_done("inf_inf");
`else
        issue("nan_x", 32'h7FC00000, 32'h3F800000, K_NOTNAN, 0.0, 32'h0, 1'b1);
        wait_done("nan_x");
        issue("inf_inf", 32'h7F800000, 32'h7F800000, K_NOTNAN, 0.0, 32'h0, 1'b1);
        wait_done("inf_inf");
`endif

        // A start pulsed while busy must be ignored
        issue("busy_ign", 32'h3F800000, 32'hBF800000, K_TOL, -0.7853981633974483, 32'h0, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        x     = 32'hBF800000;
        y     = 32'h00000000;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ign");
        @(posedge clk);
        #1;
        check_bits("busy_drop", 32'(busy), 32'h0);
        check_bits("busy_ign_no_extra", 32'(q_kind.size()), 32'h0);

        // Reset at cycle 10 of an operation aborts it without done
        done_before = n_done;
        issue("abort", 32'h3F800000, 32'h3F800000, K_TOL, 0.0, 32'h0, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_bits("abort_result", result, 32'h0000_0000);
        check_bits("abort_busy", 32'(busy), 32'h0);
        check_bits("abort_done", 32'(done), 32'h0);
        repeat (40) @(posedge clk);
        #1;
        check_bits("abort_no_done", 32'(n_done), 32'(done_before));

        issue("post_reset_60deg", 32'h3F800000, 32'h3FDDB3D7, K_TOL, 1.0471975511965976, 32'h0, 1'b1);
        wait_done("post_reset_60deg");
        repeat (3) @(posedge clk);
        #1;
        check_bits("queue_drained", 32'(q_kind.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
